// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_if.sv
// IJTAG segment signals for the gate1 data-mux override controller.
// The master drives the scan controls; the slave returns scan-out.
interface firebird7_in_gate1_tessent_data_mux_ctrl_if;
  logic ijtag_sel;
  logic ijtag_si;
  logic ijtag_ce;
  logic ijtag_se;
  logic ijtag_ue;
  logic ijtag_so;

  modport master (
    output ijtag_sel,
    output ijtag_si,
    output ijtag_ce,
    output ijtag_se,
    output ijtag_ue,
    input  ijtag_so
  );

  modport slave (
    input  ijtag_sel,
    input  ijtag_si,
    input  ijtag_ce,
    input  ijtag_se,
    input  ijtag_ue,
    output ijtag_so
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG TDR controller for the w3 data-mux override path.
// Modes: off, static override, timed pulse of count+1 tck cycles.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_ctrl_if.slave ijtag,
  input  logic [DATA_W-1:0] functional_data_in,
  output logic              ijtag_select,
  output logic [DATA_W-1:0] ijtag_data_out
);

  localparam int TDR_L = DATA_W + 2 + CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PULSE
  } state_e;

  logic [TDR_L-1:0]  sr_q, sr_d;
  logic [TDR_L-1:0]  upd_q, upd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              sel_q;
  logic [DATA_W-1:0] dout_q;

  logic              shift_en;
  logic              cap_en;
  logic              upd_en;
  logic              active;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  cnt_fld;

  assign shift_en = ijtag.ijtag_sel & ijtag.ijtag_ce & ijtag.ijtag_se;
  assign cap_en   = ijtag.ijtag_sel & ijtag.ijtag_ce & ~ijtag.ijtag_se;
  assign upd_en   = ijtag.ijtag_sel & ijtag.ijtag_ue & ~ijtag.ijtag_ce;
  assign active   = (state_q == PULSE);
  assign mode     = sr_q[DATA_W +: 2];
  assign cnt_fld  = sr_q[DATA_W+2 +: CNT_W];

  always_comb begin
    sr_d = sr_q;
    unique case (1'b1)
      shift_en: sr_d = {ijtag.ijtag_si, sr_q[TDR_L-1:1]};
      cap_en:   sr_d = {cnt_q, done_q, active, functional_data_in};
      default:  sr_d = sr_q;
    endcase
  end

  // Update restarts from the new config even mid-pulse.
  always_comb begin
    upd_d   = upd_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    priority case (1'b1)
      upd_en: begin
        upd_d  = sr_q;
        done_d = 1'b0;
        cnt_d  = '0;
        case (mode)
          2'b01:   state_d = HOLD;
          2'b10: begin
            state_d = PULSE;
            cnt_d   = cnt_fld;
          end
          default: state_d = IDLE;
        endcase
      end
      (state_q == PULSE && cnt_q == '0): begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      (state_q == PULSE): cnt_d = cnt_q - CNT_ONE;
      default: ;
    endcase
  end

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      sr_q    <= '0;
      upd_q   <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      sr_q    <= sr_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
      sel_q   <= (state_d != IDLE);
      dout_q  <= (state_d != IDLE) ? upd_d[DATA_W-1:0] : '0;
    end
  end

  assign ijtag.ijtag_so = sr_q[0];
  assign ijtag_select   = sel_q;
  assign ijtag_data_out = dout_q;

endmodule
